serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single one-bit full-adder cell (`fa`) over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in, LSB first. It provides a start/done handshake so that narrow-area datapaths can share one adder cell instead of a WIDTH-bit ripple adder.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..64.
CNT_W, $clog2(WIDTH+1), bit-counter width; local, not overridable.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  synchronous reset, active-low.
start  input  1  request; sampled only when ready=1.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry-in; captured on accepted start.
ready  output  1  high in IDLE and DONE; start is accepted in these states.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse; result valid.
sum  output  WIDTH  result; held stable from done until the next accepted start.
cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, counter=0, shift regs=0. Reset has priority over every other event and aborts a RUN in progress with no done pulse.
- States: IDLE, RUN, DONE. Encoding is localparam, 2 bits.
- IDLE, start=1: latch a→a_sh, b→b_sh, cin→carry, counter=0, clear sum_sh; go to RUN.
- RUN, each cycle:
  - fa inputs are a_sh[0], b_sh[0], carry.
  - Shift a_sh and b_sh right by 1.
  - Shift the fa sum bit into sum_sh at the MSB, shifting right.
  - carry ← fa cout; counter ← counter+1.
  - When counter==WIDTH-1 on this cycle, go to DONE.
- DONE (one cycle): done=1, ready=1. sum=sum_sh and cout=carry are registered on entry to DONE.
  - start=1 in DONE: accepted back-to-back, same actions as IDLE+start, go to RUN.
  - Otherwise go to IDLE.
- Latency: start accepted at edge T → done high in the cycle after edge T+WIDTH. That is WIDTH+1 cycles from start to done, and throughput is one add per WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing, no error flag.
- Operands changing after acceptance have no effect.
- sum and cout stay unchanged through IDLE and through the next RUN until its DONE; they do not update mid-operation.
- Arithmetic is unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- WIDTH=1: RUN lasts exactly one cycle.

Decomposition:
- No shared package needed. State localparams stay local.
- If a project-wide package exists, an `add_state_t` enum may be placed there.
- One sub-module: instantiate the existing `fa` cell (ports a, b, cin, sum, cout) as u_fa. Counter, shift registers and FSM stay in this module.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, cin=0, start at edge T → busy for 8 cycles; done at cycle T+9 with sum=0x96, cout=0.
2. a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
3. start pulsed again at cycles 2 and 5 of RUN with different operands → ignored; the first result is unchanged and exactly one done pulse occurs.
4. Assert rst_n=0 at RUN cycle 4 → the next cycle shows IDLE, sum=0, cout=0, no done. A following start of 0x10+0x20 gives 0x30.
5. Back-to-back: start held high continuously with 0x01+0x01 then 0x80+0x80 → done pulses 9 cycles apart; results are 0x02/0 then 0x00/1.
6. WIDTH=1 instance: a=1, b=1, cin=1 → done 2 cycles after start, sum=1, cout=1. Random self-check against a+b+cin over 1000 vectors at WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } add_state_t;

endpackage

// File: rtl/fa.sv
// One-bit full-adder cell shared by the serial adder datapath.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: walks one fa cell over WIDTH cycles, LSB first, with start/done handshake.
//
// state   | meaning
// IDLE    | waiting for start, ready=1
// RUN     | one operand bit pair added per cycle, busy=1
// DONE    | one-cycle done pulse, sum/cout valid, start accepted back-to-back
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    add_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic             fa_sum;
    logic             fa_cout;

    fa u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB; also correct for WIDTH=1.
    assign sum_next = WIDTH'({fa_sum, sum_sh} >> 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= cin;
                        cnt    <= '0;
                        sum_sh <= '0;
                        state  <= ST_RUN;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        ready  <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        // Result is registered from the final bit's values, not from sum_sh/carry.
                        sum   <= sum_next;
                        cout  <= fa_cout;
                        done  <= 1'b1;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
